// File: rtl/fifo_dp_ram_ctrl.sv
// Synchronous FIFO controller driving an external simple dual-port RAM
// (registered read, one-cycle latency). A 2-entry output buffer (O0/O1)
// makes the head word show-ahead and sustains one push and one pop per clock.
// Optional feature macro: FIFO_WATERMARK_EN adds registered almost_full /
// almost_empty outputs compared against AF_LEVEL / AE_LEVEL.
module fifo_dp_ram_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 14,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  ram_write_enable,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_read_enable,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  output logic [ADDR_WIDTH+1:0] count,
  output logic                  empty
`ifdef FIFO_WATERMARK_EN
  ,
  output logic                  almost_full,
  output logic                  almost_empty
`endif
);

  // Occupancy of the output buffer: EMPTY, ONE (O0 only), TWO (O0 and O1).
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  localparam logic [ADDR_WIDTH:0]   DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   ram_cnt;
  logic [ADDR_WIDTH:0]   ram_cnt_next;
  logic [ADDR_WIDTH+1:0] count_next;

  logic push;
  logic pop;
  logic fetch;

  // vld_p1: a RAM read issued last cycle, its word is on ram_data_out now.
  logic vld_p1;

  occ_e                  occ_p2;
  occ_e                  occ_next;
  logic [DATA_WIDTH-1:0] o0_p2;
  logic [DATA_WIDTH-1:0] o1_p2;
  logic                  o0_from_ram;
  logic                  o0_from_o1;
  logic                  o1_from_ram;

  assign push = wr_valid & wr_ready;
  assign pop  = rd_valid & rd_ready;

  assign rd_valid = (occ_p2 != EMPTY);
  assign rd_data  = o0_p2;

  assign ram_write_enable = push;
  assign ram_write_addr   = wr_ptr;
  assign ram_data_in      = wr_data;
  assign ram_read_addr    = rd_ptr;
  assign ram_read_enable  = fetch;

  // Fetch only while the words already committed to the buffer (held plus
  // in flight, minus the one leaving) leave room for one more.
  assign fetch = (ram_cnt != '0) && (occ_next != TWO);

  assign ram_cnt_next = ram_cnt + {{ADDR_WIDTH{1'b0}}, push}
                                - {{ADDR_WIDTH{1'b0}}, fetch};

  assign count = {1'b0, ram_cnt}
               + {{(ADDR_WIDTH+1){1'b0}}, vld_p1}
               + {{ADDR_WIDTH{1'b0}}, occ_p2};

  assign count_next = {1'b0, ram_cnt_next}
                    + {{(ADDR_WIDTH+1){1'b0}}, fetch}
                    + {{ADDR_WIDTH{1'b0}}, occ_next};

  assign empty = (count == '0);

  // Output-buffer occupancy: next state and O0/O1 load selects.
  always_comb begin
    occ_next    = occ_p2;
    o0_from_ram = 1'b0;
    o0_from_o1  = 1'b0;
    o1_from_ram = 1'b0;
    case (occ_p2)
      EMPTY: begin
        if (vld_p1) begin
          occ_next    = ONE;
          o0_from_ram = 1'b1;
        end
      end
      ONE: begin
        case ({vld_p1, pop})
          2'b10: begin
            occ_next    = TWO;
            o1_from_ram = 1'b1;
          end
          2'b01: occ_next = EMPTY;
          2'b11: o0_from_ram = 1'b1;
          default: ;
        endcase
      end
      TWO: begin
        if (pop) begin
          o0_from_o1 = 1'b1;
          if (vld_p1) begin
            o1_from_ram = 1'b1;
          end else begin
            occ_next = ONE;
          end
        end
      end
      default: occ_next = EMPTY;
    endcase
  end

  // Output-buffer occupancy state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_p2 <= EMPTY;
    end else begin
      occ_p2 <= occ_next;
    end
  end

  // Write/read pointers, RAM word count, registered wr_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ram_cnt  <= '0;
      wr_ready <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (fetch) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      ram_cnt  <= ram_cnt_next;
      wr_ready <= (ram_cnt_next < DEPTH_C);
    end
  end

  // ---- stage p0 -> p1: RAM read issued, word arrives next cycle ----
  // Fetch-in-flight flag; a reset drops any read already issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= fetch;
    end
  end

  // ---- stage p1 -> p2: RAM word captured into the output buffer ----
  // Head slot O0; cleared on reset so no stale word is ever exposed.
  always_ff @(posedge clk) begin
    if (rst) begin
      o0_p2 <= '0;
    end else if (o0_from_ram) begin
      o0_p2 <= ram_data_out;
    end else if (o0_from_o1) begin
      o0_p2 <= o1_p2;
    end
  end

  // Skid slot O1; its contents are only meaningful while occupancy is TWO.
  always_ff @(posedge clk) begin
    if (o1_from_ram) begin
      o1_p2 <= ram_data_out;
    end
  end

`ifdef FIFO_WATERMARK_EN
  localparam logic [ADDR_WIDTH+1:0] AF_C = AF_LEVEL[ADDR_WIDTH+1:0];
  localparam logic [ADDR_WIDTH+1:0] AE_C = AE_LEVEL[ADDR_WIDTH+1:0];

  // Watermarks track count_next so they change on the same edge as count.
  always_ff @(posedge clk) begin
    if (rst) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (count_next >= AF_C);
      almost_empty <= (count_next <= AE_C);
    end
  end
`else
  logic unused_count_next;
  assign unused_count_next = ^count_next;
`endif

endmodule

// File: tb/tb_fifo_dp_ram_ctrl.sv
// Bench for fifo_dp_ram_ctrl: a directed vector table for the single-word
// path, then hand-written fill / drain / concurrent / mid-run reset sequences.
// Includes a behavioural simple dual-port RAM (read-before-write).
module tb_fifo_dp_ram_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          ram_write_enable;
  logic [AW-1:0] ram_write_addr;
  logic [DW-1:0] ram_data_in;
  logic          ram_read_enable;
  logic [AW-1:0] ram_read_addr;
  logic [DW-1:0] ram_data_out;
  logic [AW+1:0] count;
  logic          empty;
`ifdef FIFO_WATERMARK_EN
  logic          almost_full;
  logic          almost_empty;
`endif

  int n_cmp = 0;
  int n_err = 0;

  fifo_dp_ram_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .AF_LEVEL  (14),
    .AE_LEVEL  (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .wr_data         (wr_data),
    .rd_valid        (rd_valid),
    .rd_ready        (rd_ready),
    .rd_data         (rd_data),
    .ram_write_enable(ram_write_enable),
    .ram_write_addr  (ram_write_addr),
    .ram_data_in     (ram_data_in),
    .ram_read_enable (ram_read_enable),
    .ram_read_addr   (ram_read_addr),
    .ram_data_out    (ram_data_out),
    .count           (count),
    .empty           (empty)
`ifdef FIFO_WATERMARK_EN
    ,
    .almost_full     (almost_full),
    .almost_empty    (almost_empty)
`endif
  );

  always #5 clk = ~clk;

  // Simple dual-port RAM: registered read every clock, old data on collision.
  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (ram_write_enable) mem[ram_write_addr] <= ram_data_in;
    ram_data_out <= mem[ram_read_addr];
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_data  = '0;
    rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic          wv;
    logic [DW-1:0] wd;
    logic          rr;
    logic          e_wrdy;
    logic          e_rv;
    logic          chk_data;
    logic [DW-1:0] e_data;
    int            e_count;
    logic          e_empty;
    logic          e_we;
    logic          e_re;
  } vec_t;

  vec_t vec [13];

  logic [DW-1:0] q [$];
  logic [DW-1:0] prev_data;
  logic          prev_stall;
  logic          acc_push;
  logic          acc_pop;
  int            nxt;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //        wv    wd     rr    wrdy  rv    chkd  data   cnt empty we    re
    vec[0]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b0};
    vec[1]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b1, 1'b0};
    vec[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b1};
    vec[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b0};
    vec[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 1, 1'b0, 1'b0, 1'b0};
    vec[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA5, 1, 1'b0, 1'b0, 1'b0};
    vec[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0};
    vec[7]  = '{1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b1, 1'b0};
    vec[8]  = '{1'b1, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1, 1'b0, 1'b1, 1'b1};
    vec[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 2, 1'b0, 1'b0, 1'b1};
    vec[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h3C, 2, 1'b0, 1'b0, 1'b0};
    vec[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h5A, 1, 1'b0, 1'b0, 1'b0};
    vec[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0};

    do_reset();
`ifdef FIFO_WATERMARK_EN
    #1;
    chk("reset_almost_full", int'(almost_full), 0);
    chk("reset_almost_empty", int'(almost_empty), 1);
`endif

    // Single-word latency and simultaneous push/pop, one row per clock.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      wr_valid = vec[i].wv;
      wr_data  = vec[i].wd;
      rd_ready = vec[i].rr;
      #1;
      chk($sformatf("vec%0d_wr_ready", i), int'(wr_ready), int'(vec[i].e_wrdy));
      chk($sformatf("vec%0d_rd_valid", i), int'(rd_valid), int'(vec[i].e_rv));
      if (vec[i].chk_data)
        chk($sformatf("vec%0d_rd_data", i), int'(rd_data), int'(vec[i].e_data));
      chk($sformatf("vec%0d_count", i), int'(count), vec[i].e_count);
      chk($sformatf("vec%0d_empty", i), int'(empty), int'(vec[i].e_empty));
      chk($sformatf("vec%0d_ram_we", i), int'(ram_write_enable), int'(vec[i].e_we));
      chk($sformatf("vec%0d_ram_re", i), int'(ram_read_enable), int'(vec[i].e_re));
    end

    // Fill: wr_valid held high for 30 clocks, only 18 words may be accepted.
    do_reset();
    nxt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      wr_valid = 1'b1;
      wr_data  = nxt[DW-1:0];
      rd_ready = 1'b0;
      #1;
      if (wr_ready) begin
        chk("fill_write_addr", int'(ram_write_addr), nxt % 16);
        nxt++;
      end
    end
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    chk("fill_accepted", nxt, 18);
    chk("fill_count", int'(count), 18);
    chk("fill_wr_ready", int'(wr_ready), 0);
    chk("fill_no_write", int'(ram_write_enable), 0);
`ifdef FIFO_WATERMARK_EN
    chk("fill_almost_full", int'(almost_full), 1);
    chk("fill_almost_empty", int'(almost_empty), 0);
`endif

    // Drain: continuous rd_ready, one word per clock, in order, no bubbles.
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      rd_ready = 1'b1;
      #1;
      chk($sformatf("drain%0d_rd_valid", i), int'(rd_valid), 1);
      chk($sformatf("drain%0d_rd_data", i), int'(rd_data), i);
      chk($sformatf("drain%0d_count", i), int'(count), 18 - i);
`ifdef FIFO_WATERMARK_EN
      chk($sformatf("drain%0d_almost_full", i), int'(almost_full), int'((18 - i) >= 14));
      chk($sformatf("drain%0d_almost_empty", i), int'(almost_empty), int'((18 - i) <= 2));
`endif
    end
    @(negedge clk);
    rd_ready = 1'b0;
    #1;
    chk("drain_empty", int'(empty), 1);
    chk("drain_count", int'(count), 0);
    chk("drain_rd_valid", int'(rd_valid), 0);

    // Concurrent traffic with random stalls, checked against a queue model.
    prev_stall = 1'b0;
    prev_data  = '0;
    nxt        = 8'h40;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      wr_valid = (c < 40) ? ($urandom_range(0, 3) != 0) : 1'b0;
      wr_data  = nxt[DW-1:0];
      rd_ready = (c < 40) ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      chk("mix_count", int'(count), q.size());
      if (prev_stall) begin
        chk("mix_stall_valid", int'(rd_valid), 1);
        chk("mix_stall_data", int'(rd_data), int'(prev_data));
      end
      if (rd_valid) begin
        if (q.size() == 0) chk("mix_valid_when_model_empty", 1, 0);
        else chk("mix_rd_data", int'(rd_data), int'(q[0]));
      end
      acc_push   = wr_valid & wr_ready;
      acc_pop    = rd_valid & rd_ready;
      prev_stall = rd_valid & ~rd_ready;
      prev_data  = rd_data;
      if (acc_pop && q.size() != 0) void'(q.pop_front());
      if (acc_push) begin
        q.push_back(wr_data);
        nxt++;
      end
    end
    @(negedge clk);
    rd_ready = 1'b0;
    wr_valid = 1'b0;
    #1;
    chk("mix_final_count", int'(count), 0);
    chk("mix_final_empty", int'(empty), 1);

    // Reset while data and a fetch are in flight: everything is discarded.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      wr_valid = 1'b1;
      wr_data  = 8'hE0 + i[DW-1:0];
    end
    @(negedge clk);
    wr_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_wr_ready", int'(wr_ready), 1);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_ram_we", int'(ram_write_enable), 0);
    chk("rst_ram_re", int'(ram_read_enable), 0);
    chk("rst_rd_data", int'(rd_data), 0);
`ifdef FIFO_WATERMARK_EN
    chk("rst_almost_full", int'(almost_full), 0);
    chk("rst_almost_empty", int'(almost_empty), 1);
`endif
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post_rst%0d_rd_valid", i), int'(rd_valid), 0);
      chk($sformatf("post_rst%0d_count", i), int'(count), 0);
      chk($sformatf("post_rst%0d_ram_re", i), int'(ram_read_enable), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_dp_ram_ctrl.md
Name: fifo_dp_ram_ctrl

Overview:
- Synchronous FIFO controller that sequences an external simple dual-port RAM (registered read, one-cycle latency, read every clock regardless of read enable).
- Converts push/pop valid-ready handshakes into RAM write/read address streams.
- Adds a 2-entry output buffer so reads are show-ahead at full throughput.
- Sits between a producer and a consumer in the FIFO datapath; the RAM is instantiated alongside it by the parent.

Parameters:
DATA_WIDTH, 8, word width (must match RAM)
ADDR_WIDTH, 4, RAM address width; DEPTH = 2**ADDR_WIDTH RAM slots
AF_LEVEL, 14, almost-full threshold on count (optional feature only)
AE_LEVEL, 2, almost-empty threshold on count (optional feature only)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
wr_valid  in  1  producer has a word
wr_ready  out  1  controller accepts a word (registered)
wr_data  in  DATA_WIDTH  push data
rd_valid  out  1  rd_data holds the head word
rd_ready  in  1  consumer takes the head word
rd_data  out  DATA_WIDTH  head word (output buffer slot O0)
ram_write_enable  out  1  to RAM write_enable
ram_write_addr  out  ADDR_WIDTH  to RAM write_addr
ram_data_in  out  DATA_WIDTH  to RAM data_in (equals wr_data)
ram_read_enable  out  1  to RAM read_enable (fetch strobe)
ram_read_addr  out  ADDR_WIDTH  to RAM read_addr
ram_data_out  in  DATA_WIDTH  from RAM data_out
count  out  ADDR_WIDTH+2  total words held (RAM + in flight + buffer), 0..DEPTH+2
empty  out  1  count==0

Behaviour:
- Reset: wr_ptr=rd_ptr=0, ram_cnt=0, f_vld=0, o_cnt=0. Outputs: wr_ready=1, rd_valid=0, count=0, empty=1, ram_write_enable=0, ram_read_enable=0, rd_data=0. RAM contents are not cleared.
- Reset mid-operation discards all held data; any fetch in flight is dropped.
- Push: push = wr_valid & wr_ready. ram_write_enable=push, ram_write_addr=wr_ptr. wr_ptr increments modulo DEPTH; natural wrap with no special case.
- wr_ready is registered as (ram_cnt_next < DEPTH). There is no combinational path from rd_ready to wr_ready.
- Fetch rule: fetch = (ram_cnt!=0) & (o_cnt + f_vld - pop < 2), where pop = rd_valid & rd_ready.
  - ram_read_addr = rd_ptr at all times. ram_read_enable = fetch.
  - On fetch: rd_ptr increments modulo DEPTH and ram_cnt decrements.
  - The slot is free once fetched: the RAM reads the old value on a same-edge write to the same address.
- f_vld is registered from fetch. In the cycle with f_vld=1, ram_data_out is valid and must be captured at that edge, unconditionally.
  - Capture into O0 if O0 is empty or being popped this cycle; otherwise into O1 (skid).
  - The fetch rule guarantees space.
- Pop shifts O1 into O0 when O1 is valid. rd_valid = (o_cnt!=0). rd_data is held stable while rd_valid & !rd_ready.
- Latency: push accepted at edge E0 -> fetch in the cycle after E0 -> rd_valid=1 after E2 (2 cycles, empty FIFO).
- Throughput: 1 push and 1 pop per cycle in steady state.
- ram_cnt_next = ram_cnt + push - fetch; both may occur in the same cycle.
- count = ram_cnt + f_vld + o_cnt; it changes by push - pop per cycle. Maximum capacity is DEPTH+2.
- Push with wr_ready=0 is ignored. rd_ready with rd_valid=0 is ignored.
- No state machine beyond the O0/O1 occupancy states EMPTY(0), ONE(1), TWO(2).

Optional Feature:
- Macro: FIFO_WATERMARK_EN.
- Defined: adds outputs almost_full (count >= AF_LEVEL) and almost_empty (count <= AE_LEVEL), both registered and updated on the same edge as count. Reset values: almost_full=0, almost_empty=1.
- Undefined: the ports and logic are absent, and AF_LEVEL/AE_LEVEL are unused.

Test Plan:
- Reset, then idle -> wr_ready=1, rd_valid=0, empty=1, count=0; the RAM write/read enables stay 0.
- Push 0xA5 once into an empty FIFO, rd_ready=0 -> rd_valid rises 2 cycles after the accepting edge, rd_data=0xA5, count=1.
- Push 0x00..0x11 (18 words), rd_ready=0 -> wr_ready=0 after the 16th RAM slot fills; count=18; no further pushes accepted.
- From full, pop all 18 words with rd_ready=1 continuously -> the words arrive in order with no bubbles; empty=1 at the end.
- Simultaneous push/pop for 40 cycles with random rd_ready stalls -> in-order data, pointers wrap past 15, count stays consistent with push-pop, and rd_data is stable during stalls.
- Fill with 5 words, assert rst for 1 cycle -> all outputs return to reset values; old data is never presented on rd_data.
- FIFO_WATERMARK_EN defined: count 14 -> almost_full=1; count 2 -> almost_empty=1.
